fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter QDEPTH, default 4: instruction queue entries; power of two, >=2.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-low (asserted at 0).
REQ-005 imem_req  output  1  fetch request to instruction memory.
REQ-006 imem_addr  output  32  byte address of request; bits [1:0] always 0.
REQ-007 imem_gnt  input  1  memory accepts request this cycle (req & gnt = issue).
REQ-008 imem_rvalid  input  1  response valid, in issue order, >=1 cycle after issue.
REQ-009 imem_rdata  input  32  instruction word of the response.
REQ-010 if_valid  output  1  queue head valid toward decode.
REQ-011 if_inst / if_pc  output  32 / 32  head instruction and its address.
REQ-012 id_ready  input  1  decode consumes head when if_valid & id_ready.
REQ-013 redirect / redirect_pc  input  1 / 32  mispredicted branch (always-not-taken) target from EX.
REQ-014 halt  input  1  stop fetching (ecall/halt reached).

Function
REQ-015 FSM states IDLE, FETCH, HALTED; IDLE -> FETCH unconditionally one cycle after reset release; FETCH -> HALTED on halt; HALTED exits only by reset.
REQ-016 Issue in FETCH only when outstanding < 2 and outstanding + queue count < QDEPTH (credit rule; queue never overflows).
REQ-017 imem_req held with imem_addr stable until imem_gnt, except on redirect where address retargets without deassert.
REQ-018 On issue fetch_pc += 4, modulo 2^32 (0xFFFF_FFFC wraps to 0).
REQ-019 Pending-PC tracker (depth 2) stores issued addresses; each accepted response enqueues {pc, rdata} into queue.
REQ-020 Simultaneous push and pop permitted at any occupancy; pop when empty is a no-op.
REQ-021 Latency: 1-cycle memory with id_ready=1 yields sustained 1 instruction/cycle; first if_valid no earlier than 2 cycles after first issue.
REQ-022 redirect: next edge flushes queue, fetch_pc <= {redirect_pc[31:2],2'b00}, discard_cnt <= outstanding responses not returned (including a gnt in same cycle, excluding an rvalid in same cycle); pop in that cycle ignored.
REQ-023 Responses arriving with discard_cnt > 0 are dropped and decrement discard_cnt; first request to redirect target asserted the cycle after redirect.
REQ-024 redirect and halt same cycle: redirect applied, state -> HALTED.
REQ-025 HALTED: no new requests; in-flight responses still enqueued; queue drains to decode normally.
REQ-026 imem_rvalid with outstanding == 0 ignored (stale pre-reset response).
REQ-027 if_inst = 0 and if_pc = 0 whenever if_valid = 0.

Reset
REQ-028 On reset assertion, asynchronously: state IDLE, fetch_pc RESET_PC, queue/tracker empty, outstanding 0, discard_cnt 0.
REQ-029 Reset outputs: imem_req 0, imem_addr RESET_PC, if_valid 0, if_inst 0, if_pc 0.
REQ-030 Reset mid-transfer abandons in-flight requests; no response from before reset reaches decode.

Structure
REQ-031 Shared package fetch_pkg holds XLEN=32, state encodings, default RESET_PC, queue-entry {pc, inst} layout.
REQ-032 Single sub-module fetch_queue: synchronous FIFO, QDEPTH x 64 bits, push/pop/flush, count output.
REQ-033 Assertions: no push when full, discard_cnt <= 2, outstanding <= 2.

Verification
REQ-034 Reset, gnt=1, 1-cycle latency, id_ready=1 -> if_pc 0,4,8,12 on consecutive cycles, no bubbles after first.
REQ-035 id_ready=0 for 10 cycles -> queue fills to 4, imem_req drops, pc 0..12 delivered in order after release, none lost.
REQ-036 Redirect to 0x40 with 2 outstanding, 3-cycle latency -> both stale responses dropped, next if_pc = 0x40.
REQ-037 redirect_pc 0x43 -> imem_addr 0x40; fetch_pc 0xFFFF_FFFC -> next request address 0.
REQ-038 halt with 1 outstanding -> that response delivered, no further imem_req; redirect afterward ignored.
REQ-039 Reset asserted with request in flight, stale rvalid after release -> ignored; first if_pc = RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch front end: state encoding,
// queue entry layout and the reset fetch address.
package fetch_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    HALTED  = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fq_entry_t;

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/fetch_queue.sv
// Synchronous instruction FIFO of {pc, inst} entries with flush.
// Pop on empty is a no-op; push and pop may coincide at any occupancy.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int QDEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push,
  input  fq_entry_t                 push_data,
  input  logic                      pop,
  input  logic                      flush,
  output fq_entry_t                 head,
  output logic [$clog2(QDEPTH):0]   count
);
  localparam int AW = $clog2(QDEPTH);
  localparam logic [AW:0] CNT_FULL = QDEPTH[AW:0];

  fq_entry_t     mem [QDEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   cnt;
  logic          empty, full, do_push, do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CNT_FULL);
  assign do_pop  = pop && !empty;
  // a pop in the same cycle frees the slot a full-queue push needs
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign count = cnt;

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
    !(push && full && !pop));
endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: issues word fetches under a credit rule,
// tracks up to two in-flight requests, and drops responses made stale by redirect.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int              QDEPTH   = 4
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            if_valid,
  output logic [XLEN-1:0] if_inst,
  output logic [XLEN-1:0] if_pc,
  input  logic            id_ready,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            halt
);
  localparam int AW = $clog2(QDEPTH);

  fetch_state_e    state, state_nxt;
  logic [XLEN-1:0] fetch_pc;
  logic [1:0]      outstanding, discard_cnt;
  logic [XLEN-1:0] pend_pc [2];
  logic            pend_wr, pend_rd;
  logic            issue, rsp, redir, credit, push, pop;
  logic [AW:0]     q_count;
  fq_entry_t       q_head, q_in;

  // redirect only matters while fetching; once halted it is ignored
  assign redir  = redirect && (state == FETCH);
  assign rsp    = imem_rvalid && (outstanding != 2'd0);
  assign credit = (outstanding < 2'd2) && ((int'(outstanding) + int'(q_count)) < QDEPTH);

  assign imem_req  = (state == FETCH) && !halt && credit;
  assign imem_addr = fetch_pc;
  assign issue     = imem_req && imem_gnt;
  assign push      = rsp && (discard_cnt == 2'd0) && !redir;
  assign pop       = if_valid && id_ready && !redir;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = FETCH;
      FETCH:   if (halt) state_nxt = HALTED;
      HALTED:  state_nxt = HALTED;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc    <= align_word(RESET_PC);
      outstanding <= 2'd0;
      discard_cnt <= 2'd0;
      pend_wr     <= 1'b0;
      pend_rd     <= 1'b0;
    end else begin
      if (redir)      fetch_pc <= align_word(redirect_pc);
      else if (issue) fetch_pc <= fetch_pc + 32'd4;
      outstanding <= outstanding + {1'b0, issue} - {1'b0, rsp};
      if (issue) pend_wr <= ~pend_wr;
      if (rsp)   pend_rd <= ~pend_rd;
      // everything still in flight after this edge belongs to the wrong path
      if (redir)                            discard_cnt <= outstanding + {1'b0, issue} - {1'b0, rsp};
      else if (rsp && discard_cnt != 2'd0)  discard_cnt <= discard_cnt - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (issue) pend_pc[pend_wr] <= fetch_pc;
  end

  assign q_in = '{pc: pend_pc[pend_rd], inst: imem_rdata};

  fetch_queue #(.QDEPTH(QDEPTH)) u_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (q_in),
    .pop       (pop),
    .flush     (redir),
    .head      (q_head),
    .count     (q_count)
  );

  assign if_valid = (q_count != '0);
  assign if_inst  = if_valid ? q_head.inst : '0;
  assign if_pc    = if_valid ? q_head.pc   : '0;

  a_bounds: assert property (@(posedge clk) disable iff (!reset)
    (outstanding <= 2'd2) && (discard_cnt <= 2'd2));
endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: a latency-programmable memory model answers
// granted requests in order; expected pcs are queued at issue and checked at delivery.
module tb_fetch_ctrl;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef struct { logic [31:0] addr; int due; } mem_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req, imem_gnt = 1'b0, imem_rvalid = 1'b0;
  logic [31:0] imem_addr, imem_rdata = '0;
  logic        if_valid, id_ready = 1'b0, redirect = 1'b0, halt = 1'b0;
  logic [31:0] if_inst, if_pc, redirect_pc = '0;

  mem_t        rsp_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] dlv_q[$];
  int          nerr = 0, nchk = 0, cyc = 0, lat = 1;
  int          first_issue_cyc = -1, first_valid_cyc = -1;
  bit          gnt_en = 1'b0, force_stale = 1'b0, halted_m = 1'b0;

  always #5 clk = ~clk;

  fetch_ctrl #(.RESET_PC(RESET_PC), .QDEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc), .id_ready(id_ready),
    .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt)
  );

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // One clock: drive memory, sample mid-cycle, update the model, advance.
  task automatic cycle();
    logic [31:0] e;
    bit drove, redir_m;
    drove = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    if (force_stale) begin
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hDEAD_BEEF;
    end else if (rsp_q.size() != 0 && rsp_q[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = inst_of(rsp_q[0].addr);
      drove = 1'b1;
    end
    imem_gnt = gnt_en;
    #4;
    redir_m = redirect && !halted_m;
    if (if_valid && id_ready && !redir_m) begin
      nchk++;
      if (exp_q.size() == 0) begin
        nerr++;
        $display("FAIL deliver_unexpected: got pc=%h inst=%h, required none", if_pc, if_inst);
      end else begin
        e = exp_q.pop_front();
        if (if_pc !== e || if_inst !== inst_of(e)) begin
          nerr++;
          $display("FAIL deliver: got pc=%h inst=%h, required pc=%h inst=%h", if_pc, if_inst, e, inst_of(e));
        end
      end
      dlv_q.push_back(if_pc);
    end
    if (!if_valid) begin
      nchk++;
      if (if_pc !== '0 || if_inst !== '0) begin
        nerr++;
        $display("FAIL idle_zero: got pc=%h inst=%h, required 0/0", if_pc, if_inst);
      end
    end
    if (halted_m) begin
      nchk++;
      if (imem_req !== 1'b0) begin
        nerr++;
        $display("FAIL halt_no_req: got imem_req=%b, required 0", imem_req);
      end
    end
    if (if_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (drove) void'(rsp_q.pop_front());
    if (redir_m) exp_q.delete();
    if (imem_req && imem_gnt) begin
      rsp_q.push_back('{addr: imem_addr, due: cyc + lat});
      if (!redir_m) exp_q.push_back(imem_addr);
      if (first_issue_cyc < 0) first_issue_cyc = cyc;
    end
    if (halt) halted_m = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_model();
    rsp_q.delete(); exp_q.delete(); dlv_q.delete();
    halted_m = 1'b0; first_issue_cyc = -1; first_valid_cyc = -1;
    force_stale = 1'b0; redirect = 1'b0; halt = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    gnt_en = 1'b0;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    @(posedge clk); #3;
    nchk++;
    if (imem_req !== 1'b0 || imem_addr !== RESET_PC || if_valid !== 1'b0 || if_inst !== '0 || if_pc !== '0) begin
      nerr++;
      $display("FAIL reset_outputs: got req=%b addr=%h v=%b inst=%h pc=%h, required 0/%h/0/0/0",
               imem_req, imem_addr, if_valid, if_inst, if_pc, RESET_PC);
    end
    @(posedge clk); #1; reset = 1'b1; imem_gnt = 1'b0;
    #3; nchk++;
    if (imem_req !== 1'b0) begin nerr++; $display("FAIL idle_no_req: got %b, required 0", imem_req); end
    @(posedge clk); #4; nchk++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
      nerr++; $display("FAIL first_req: got req=%b addr=%h, required 1/%h", imem_req, imem_addr, RESET_PC);
    end
    repeat (2) @(posedge clk);
    #4; nchk++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
      nerr++; $display("FAIL req_hold: got req=%b addr=%h, required 1/%h", imem_req, imem_addr, RESET_PC);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_stream();
    do_reset();
    lat = 1; gnt_en = 1'b1; id_ready = 1'b1;
    repeat (14) cycle();
    nchk++;
    if (first_issue_cyc < 0 || first_valid_cyc - first_issue_cyc < 2) begin
      nerr++; $display("FAIL first_latency: got issue@%0d valid@%0d, required gap>=2", first_issue_cyc, first_valid_cyc);
    end
    nchk++;
    if (dlv_q.size() != cyc - first_valid_cyc) begin
      nerr++; $display("FAIL no_bubbles: got %0d delivered, required %0d", dlv_q.size(), cyc - first_valid_cyc);
    end
    for (int i = 0; i < 4; i++) begin
      nchk++;
      if (dlv_q.size() <= i || dlv_q[i] !== RESET_PC + 32'(4 * i)) begin
        nerr++; $display("FAIL stream_pc%0d: got %h, required %h", i, (dlv_q.size() > i) ? dlv_q[i] : 32'hx, RESET_PC + 32'(4 * i));
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    lat = 1; gnt_en = 1'b1; id_ready = 1'b0;
    repeat (10) cycle();
    nchk++;
    if (imem_req !== 1'b0 || if_valid !== 1'b1 || if_pc !== RESET_PC || exp_q.size() != 4 || rsp_q.size() != 0) begin
      nerr++;
      $display("FAIL bp_full: got req=%b v=%b pc=%h issued=%0d inflight=%0d, required 0/1/%h/4/0",
               imem_req, if_valid, if_pc, exp_q.size(), rsp_q.size(), RESET_PC);
    end
    id_ready = 1'b1;
    repeat (6) cycle();
    gnt_en = 1'b0;
    repeat (8) cycle();
    nchk++;
    if (exp_q.size() != 0) begin nerr++; $display("FAIL bp_lost: got %0d undelivered, required 0", exp_q.size()); end
    for (int i = 0; i < 4; i++) begin
      nchk++;
      if (dlv_q.size() <= i || dlv_q[i] !== RESET_PC + 32'(4 * i)) begin
        nerr++; $display("FAIL bp_order%0d: got %h, required %h", i, (dlv_q.size() > i) ? dlv_q[i] : 32'hx, RESET_PC + 32'(4 * i));
      end
    end
  endtask

  task automatic test_redirect();
    int n, mark;
    do_reset();
    lat = 3; gnt_en = 1'b1; id_ready = 1'b1;
    n = 0;
    while (rsp_q.size() < 2 && n < 10) begin cycle(); n++; end
    nchk++;
    if (rsp_q.size() != 2) begin nerr++; $display("FAIL redir_setup: got %0d in flight, required 2", rsp_q.size()); end
    mark = dlv_q.size();
    redirect = 1'b1; redirect_pc = 32'h0000_0043;
    cycle();
    redirect = 1'b0;
    nchk++;
    if (imem_addr !== 32'h0000_0040) begin nerr++; $display("FAIL redir_align: got %h, required 00000040", imem_addr); end
    n = 0;
    while (dlv_q.size() == mark && n < 20) begin cycle(); n++; end
    nchk++;
    if (dlv_q.size() <= mark || dlv_q[mark] !== 32'h0000_0040) begin
      nerr++; $display("FAIL redir_target: got %h, required 00000040", (dlv_q.size() > mark) ? dlv_q[mark] : 32'hx);
    end
  endtask

  task automatic test_wrap();
    int mark;
    do_reset();
    lat = 1; gnt_en = 1'b1; id_ready = 1'b1;
    repeat (4) cycle();
    mark = dlv_q.size();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    cycle();
    redirect = 1'b0;
    nchk++;
    if (imem_addr !== 32'hFFFF_FFFC) begin nerr++; $display("FAIL wrap_addr: got %h, required fffffffc", imem_addr); end
    repeat (8) cycle();
    nchk++;
    if (dlv_q.size() < mark + 2 || dlv_q[mark] !== 32'hFFFF_FFFC || dlv_q[mark + 1] !== 32'h0) begin
      nerr++; $display("FAIL wrap_seq: got %0d deliveries after redirect, required fffffffc then 00000000", dlv_q.size() - mark);
    end
  endtask

  task automatic test_halt();
    int n;
    do_reset();
    lat = 3; gnt_en = 1'b1; id_ready = 1'b0;
    n = 0;
    while (rsp_q.size() < 1 && n < 10) begin cycle(); n++; end
    halt = 1'b1;
    cycle();
    halt = 1'b0;
    repeat (3) cycle();
    redirect = 1'b1; redirect_pc = 32'h0000_0080;
    cycle();
    redirect = 1'b0;
    id_ready = 1'b1;
    repeat (4) cycle();
    nchk++;
    if (dlv_q.size() != 1 || dlv_q[0] !== RESET_PC || exp_q.size() != 0) begin
      nerr++; $display("FAIL halt_drain: got %0d delivered, %0d pending, required 1 (pc %h), 0", dlv_q.size(), exp_q.size(), RESET_PC);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    lat = 3; gnt_en = 1'b1; id_ready = 1'b1;
    repeat (3) cycle();
    #2; reset = 1'b0; #1;
    nchk++;
    if (imem_req !== 1'b0 || if_valid !== 1'b0 || imem_addr !== RESET_PC) begin
      nerr++; $display("FAIL reset_async: got req=%b v=%b addr=%h, required 0/0/%h", imem_req, if_valid, imem_addr, RESET_PC);
    end
    clear_model();
    @(posedge clk); #1;
    reset = 1'b1;
    force_stale = 1'b1;
    cycle();
    force_stale = 1'b0;
    repeat (10) cycle();
    nchk++;
    if (dlv_q.size() == 0 || dlv_q[0] !== RESET_PC) begin
      nerr++; $display("FAIL reset_first_pc: got %h, required %h", (dlv_q.size() > 0) ? dlv_q[0] : 32'hx, RESET_PC);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_halt();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
